bsg_relay_fifo_param: RTL and testbench
=======================================

// Module: bsg_relay_fifo_param
// PURPOSE
//  Parametrised successor to the fixed 2-entry relay FIFO: ready/valid in, valid/ready out, depth els_p.
//  Adds an occupancy count, a programmable almost-full flag and a synchronous flush.
//  Sits on long inter-tile paths as a retiming/elastic stage; back-to-back throughput 1 word/cycle.
// PARAMETERS
//  width_p        16   data width in bits (>=1)
//  els_p          4    entries; power of two, >=2
//  almost_full_p  3    almost_full_o asserts when count >= almost_full_p (1..els_p)
// PORTS
//  clk_i          in   1              clock, all state on rising edge
//  reset_n_i      in   1              synchronous reset, active-low
//  flush_i        in   1              synchronous clear of contents (same effect as reset, 1 cycle)
//  v_i            in   1              input valid
//  data_i         in   width_p        input data
//  ready_o        out  1              space available (= ~full); enq = v_i & ready_o
//  v_o            out  1              output valid (= ~empty)
//  data_o         out  width_p        head entry; undefined when v_o=0
//  ready_i        in   1              consumer ready; deq = v_o & ready_i
//  count_o        out  clog2(els_p+1) entries held
//  almost_full_o  out  1              count_o >= almost_full_p
// BEHAVIOUR
//  Reset (reset_n_i=0 at edge): head=tail=0, count=0, empty=1, full=0 -> ready_o=1, v_o=0,
//   count_o=0, almost_full_o=0 (unless almost_full_p=0, disallowed). Memory contents not reset.
//  Reset dominates flush; flush dominates enq/deq: flush cycle drops any enq/deq, next cycle = reset state.
//  ready_o and v_o depend only on registers (no combinational v_i->ready_o or ready_i->v_o path).
//  ready_o is not gated by flush_i; a handshake in the flush cycle is legal and discarded.
//  Enq: write data_i at tail, tail <= tail+1 mod els_p (natural wrap, log2 pointer width).
//  Deq: head <= head+1 mod els_p; data_o = mem[head] combinationally from registered head.
//  Read port: registered copy of next-head drives the mux select (as in the 2-entry design) so data_o
//   is a pure register->mux path; must equal mem[head] every cycle.
//  Count: +1 on enq only, -1 on deq only, unchanged on both or neither; never exceeds els_p.
//  full  <= (count==els_p-1) & enq & ~deq | full & ~deq.
//  empty <= (count==1) & deq & ~enq | empty & ~enq.
//  Simultaneous enq+deq: legal whenever 0<count<els_p; full/empty unchanged.
//  Enq when full impossible (ready_o=0); deq when empty impossible (v_o=0). Upstream asserting v_i while
//   ready_o=0 holds data; no loss, no duplication.
//  Write-then-read same entry: data written at edge N is visible on data_o in cycle N+1 (1-cycle latency
//   empty->v_o). No fall-through bypass.
//  Assertions (sim only): count_o==0 <-> ~v_o; count_o==els_p <-> ~ready_o; els_p power of two.
// STRUCTURE
//  Package bsg_relay_fifo_pkg: function ptr_width(els) = clog2(els); count width = clog2(els+1);
//   localparam defaults above.
//  Sub-module bsg_relay_fifo_mem: 1r1w flop array, els_p x width_p, write enable+addr, async read
//   addr; no reset on storage.
//  Top: pointers, count, full/empty flags, registered read select, flush/reset priority.
// TESTING (width_p=16, els_p=4, almost_full_p=3)
//  Reset: hold reset_n_i=0 2 cycles -> ready_o=1, v_o=0, count_o=0, almost_full_o=0.
//  Fill: push 0xA000..0xA003, ready_i=0 -> count_o 1,2,3,4; almost_full_o=1 at 3; ready_o=0 after 4th;
//   extra v_i ignored, count stays 4.
//  Drain: ready_i=1 -> data_o 0xA000,0xA001,0xA002,0xA003 in order, v_o=0 after 4th, count_o=0.
//  Streaming: v_i=ready_i=1 for 20 cycles, data 0..19 -> output 0..19 with 1-cycle lag, count_o=1 steady,
//   pointers wrap 5 times with no loss.
//  Flush: 3 entries held, flush_i=1 with v_i=1 data 0xBEEF -> next cycle count_o=0, v_o=0; 0xBEEF never
//   appears on data_o.
//  Random: 10k cycles random v_i/ready_i/flush_i vs scoreboard queue; data, count_o, almost_full_o match.

Source files
------------

// File: rtl/bsg_relay_fifo_pkg.sv
// Shared sizing helpers and default parameters for the parametrised relay FIFO.
package bsg_relay_fifo_pkg;

  localparam int width_default       = 16;
  localparam int els_default         = 4;
  localparam int almost_full_default = 3;

  // Pointer width for an els-entry ring; never narrower than one bit.
  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  // Occupancy counter must represent 0..els inclusive.
  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_relay_fifo_mem.sv
// 1r1w flop array: synchronous write, asynchronous read, storage is not reset.
module bsg_relay_fifo_mem
  import bsg_relay_fifo_pkg::*;
#(
  parameter int width_p = width_default,
  parameter int els_p   = els_default,
  parameter int addr_w  = ptr_width(els_default)
) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic [addr_w-1:0]  w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic [addr_w-1:0]  r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bsg_relay_fifo_param.sv
// Parametrised relay FIFO: elastic ready/valid stage with occupancy count,
// almost-full flag and single-cycle synchronous flush.
module bsg_relay_fifo_param
  import bsg_relay_fifo_pkg::*;
#(
  parameter int width_p       = width_default,
  parameter int els_p         = els_default,
  parameter int almost_full_p = almost_full_default
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,
  input  logic                          v_i,
  input  logic [width_p-1:0]            data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  input  logic                          ready_i,
  output logic [count_width(els_p)-1:0] count_o,
  output logic                          almost_full_o
);

  localparam int ptr_w = ptr_width(els_p);
  localparam int cnt_w = count_width(els_p);

  localparam logic [ptr_w-1:0] ptr_one     = 1;
  localparam logic [cnt_w-1:0] cnt_one     = 1;
  localparam logic [cnt_w-1:0] cnt_last    = cnt_w'(els_p - 1);
  localparam logic [cnt_w-1:0] cnt_af      = cnt_w'(almost_full_p);

  logic [ptr_w-1:0] head, tail, rd_sel, head_next;
  logic [cnt_w-1:0] count;
  logic             full, empty;
  logic             enq, deq;

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_i;

  assign head_next = deq ? head + ptr_one : head;

  // Pointer, count and flag state; reset beats flush, flush beats any handshake.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || flush_i) begin
      head   <= '0;
      tail   <= '0;
      rd_sel <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      head   <= head_next;
      rd_sel <= head_next;
      if (enq) tail <= tail + ptr_one;
      case ({enq, deq})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
      full  <= ((count == cnt_last) & enq & ~deq) | (full & ~deq);
      empty <= ((count == cnt_one) & deq & ~enq) | (empty & ~enq);
    end
  end

  // Writes in a flush or reset cycle are discarded along with the pointers.
  bsg_relay_fifo_mem #(
    .width_p (width_p),
    .els_p   (els_p),
    .addr_w  (ptr_w)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq & reset_n_i & ~flush_i),
    .w_addr_i (tail),
    .w_data_i (data_i),
    .r_addr_i (rd_sel),
    .r_data_o (data_o)
  );

  assign count_o       = count;
  assign almost_full_o = (count >= cnt_af);

`ifndef SYNTHESIS
  // Consistency between occupancy and the handshake flags, plus a depth sanity check.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ((els_p & (els_p - 1)) == 0) else $error("els_p must be a power of two");
      assert ((count == '0) == empty) else $error("count/empty disagree");
      assert ((count == cnt_w'(els_p)) == full) else $error("count/full disagree");
      assert (rd_sel == head) else $error("read select diverged from head");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_relay_fifo_param.sv
// Directed and scoreboard checks for the parametrised relay FIFO (16b x 4, almost-full at 3).
module tb_bsg_relay_fifo_param;

  logic        clk = 1'b0;
  logic        reset_n, flush, v_in, ready_in;
  logic [15:0] data_in;
  logic        ready_out, v_out, af;
  logic [15:0] data_out;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_pass = 0;

  bsg_relay_fifo_param #(.width_p(16), .els_p(4), .almost_full_p(3)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .flush_i       (flush),
    .v_i           (v_in),
    .data_i        (data_in),
    .ready_o       (ready_out),
    .v_o           (v_out),
    .data_o        (data_out),
    .ready_i       (ready_in),
    .count_o       (count),
    .almost_full_o (af)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  bit          m_enq, m_deq;

  initial begin
    reset_n = 1'b0; flush = 1'b0; v_in = 1'b0; ready_in = 1'b0; data_in = '0;

    // Reset
    step(); step();
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_v",     32'(v_out),     32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_af",    32'(af),        32'd0);
    reset_n = 1'b1;

    // Fill with consumer stalled
    for (int i = 0; i < 4; i++) begin
      v_in = 1'b1; data_in = 16'hA000 + 16'(i);
      step();
      chk("fill_count", 32'(count),     32'(i + 1));
      chk("fill_af",    32'(af),        32'(i + 1 >= 3));
      chk("fill_ready", 32'(ready_out), 32'(i + 1 < 4));
    end
    data_in = 16'hDEAD;
    step(); step();
    chk("full_hold_count", 32'(count), 32'd4);
    v_in = 1'b0;

    // Drain in order
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_v",    32'(v_out),    32'd1);
      chk("drain_data", 32'(data_out), 32'(16'hA000 + 16'(i)));
      step();
    end
    chk("drain_v_end",     32'(v_out), 32'd0);
    chk("drain_count_end", 32'(count), 32'd0);

    // Streaming at one word per cycle with a single-cycle lag
    for (int i = 0; i < 20; i++) begin
      v_in = 1'b1; data_in = 16'(i);
      if (i > 0) begin
        chk("stream_data",  32'(data_out), 32'(i - 1));
        chk("stream_count", 32'(count),    32'd1);
      end
      step();
    end
    v_in = 1'b0;
    chk("stream_last", 32'(data_out), 32'd19);
    step();
    chk("stream_empty", 32'(count), 32'd0);

    // Flush with three entries and a concurrent handshake
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_in = 1'b1; data_in = 16'hC000 + 16'(i);
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; data_in = 16'hBEEF;
    step();
    flush = 1'b0; v_in = 1'b0;
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_v",     32'(v_out),     32'd0);
    chk("flush_ready", 32'(ready_out), 32'd1);
    v_in = 1'b1; data_in = 16'h1234;
    step();
    v_in = 1'b0;
    chk("post_flush_v",    32'(v_out),    32'd1);
    chk("post_flush_data", 32'(data_out), 32'h1234);
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    chk("post_flush_empty", 32'(count), 32'd0);

    // Random traffic against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_v",     32'(v_out),     32'(q.size() != 0));
      chk("rnd_ready", 32'(ready_out), 32'(q.size() < 4));
      chk("rnd_count", 32'(count),     32'(q.size()));
      chk("rnd_af",    32'(af),        32'(q.size() >= 3));
      if (q.size() != 0) chk("rnd_data", 32'(data_out), 32'(q[0]));
      v_in     = ($urandom_range(0, 2) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      data_in  = 16'($urandom);
      m_enq = v_in && (q.size() < 4);
      m_deq = ready_in && (q.size() != 0);
      if (flush) q.delete();
      else begin
        if (m_deq) void'(q.pop_front());
        if (m_enq) q.push_back(data_in);
      end
      step();
    end
    flush = 1'b0; v_in = 1'b0; ready_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
